// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, default base address and address decode for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;

  typedef struct packed {
    logic        err;
    logic [29:0] word;
  } dec_t;

  function automatic dec_t dmem_decode(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] depth);
    dec_t        d;
    logic [31:0] w;
    w = (addr - base) >> 2;
    d.err = (addr[1:0] != 2'b00) || (w >= depth);
    d.word = w[29:0];
    return d;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word RAM with byte-write mask and a read register that only loads on read enable
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Masked word write; read data is captured once and held until the next read
  always_ff @(posedge clk) begin
    if (en_i && we_i)
      for (int i = 0; i < 4; i++)
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    if (en_i && !we_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time load/store responder with fixed latency; DMEM_BYTE_EN_EN adds req_be byte-write enables
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_EN_EN
  input  logic [3:0]  req_be,
`endif
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, err_q;
  logic        accept;
  dec_t        dec;
  logic [3:0]  be;
  logic [31:0] ram_rdata;

  assign dec = dmem_decode(req_addr, BASE_ADDR, 32'(DEPTH));
  // Reset blocks acceptance so a write presented during reset never commits
  assign accept = req_valid && req_ready && !rst;

`ifdef DMEM_BYTE_EN_EN
  assign be = req_be;
`else
  assign be = 4'hF;
`endif

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk     (clk),
    .en_i    (accept && !dec.err),
    .we_i    (req_we),
    .be_i    (be),
    .addr_i  (AW'(dec.word)),
    .wdata_i (req_wdata),
    .rdata_o (ram_rdata)
  );

  // State, latency counter and captured request attributes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q  <= req_we;
        err_q <= dec.err;
      end
    end
  end

  // Next state: count down LATENCY-1 cycles in WAIT, then a single RESP cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = (LATENCY > 1) ? WAIT : RESP;
      cnt_d   = 4'(LATENCY - 1);
    end else if (state_q == WAIT) begin
      state_d = (cnt_q == 4'd1) ? RESP : WAIT;
      cnt_d   = cnt_q - 4'd1;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end

  // Outputs: response fields are forced to zero outside the response strobe
  always_comb begin
    req_ready = state_q == IDLE;
    rsp_valid = state_q == RESP;
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !we_q && !err_q) ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (default build and DMEM_BYTE_EN_EN build)
module tb_dmem_responder;

  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = 4'hF;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMEM_BYTE_EN_EN
    .req_be    (req_be),
`endif
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          acc_cyc[$];
  logic [31:0] mdl [int];
  int          cyc = 0;
  int          acc_cnt = 0;
  int          rsp_cnt = 0;
  int          busy_until = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: model of ready/acceptance, scoreboard push on accept and pop on response
  always @(negedge clk) begin
    exp_t        e;
    logic        exp_v, exp_ready, er;
    logic [31:0] off, w;
    int          idx;
    exp_v = (sb.size() > 0) && (sb[0].due == cyc);
    tests++;
    if (rsp_valid !== exp_v) begin
      fails++;
      $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_v);
    end
    if (exp_v) begin
      e = sb.pop_front();
      if (rsp_valid === 1'b1) begin
        rsp_cnt++;
        last_rdata = rsp_rdata;
        last_err = rsp_err;
        tests += 2;
        if (rsp_err !== e.err) begin
          fails++;
          $display("FAIL rsp_err cyc=%0d got=%b exp=%b", cyc, rsp_err, e.err);
        end
        if (rsp_rdata !== e.rdata) begin
          fails++;
          $display("FAIL rsp_rdata cyc=%0d got=%h exp=%h", cyc, rsp_rdata, e.rdata);
        end
      end
    end else if (rsp_valid === 1'b0) begin
      tests++;
      if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
        fails++;
        $display("FAIL idle_outputs cyc=%0d got rdata=%h err=%b exp 0", cyc, rsp_rdata, rsp_err);
      end
    end
    if (rst) begin
      sb.delete();
      busy_until = cyc;
    end else begin
      exp_ready = cyc > busy_until;
      tests++;
      if (req_ready !== exp_ready) begin
        fails++;
        $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
      end
      if (req_valid && exp_ready) begin
        off = req_addr - BASE;
        er = (req_addr[1:0] != 2'b00) || ((off >> 2) >= DEPTH);
        idx = int'(off >> 2);
        e.due = cyc + LAT;
        e.err = er;
        e.rdata = '0;
        if (!er) begin
          if (req_we) begin
            w = mdl.exists(idx) ? mdl[idx] : 32'h0;
`ifdef DMEM_BYTE_EN_EN
            for (int b = 0; b < 4; b++) if (req_be[b]) w[8*b +: 8] = req_wdata[8*b +: 8];
`else
            w = req_wdata;
`endif
            mdl[idx] = w;
          end else begin
            e.rdata = mdl.exists(idx) ? mdl[idx] : 'x;
          end
        end
        sb.push_back(e);
        acc_cyc.push_back(cyc);
        acc_cnt++;
        busy_until = cyc + LAT;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int s;
    s = acc_cnt;
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    req_be = be;
    for (int i = 0; i < 50 && acc_cnt == s; i++) tick();
    req_valid = 1'b0;
    if (acc_cnt == s) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout addr=%h", a);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout pending=%0d exp 0", sb.size());
      sb.delete();
    end
    tick();
  endtask

  task automatic check_last(input string name, input logic err, input logic [31:0] rdata);
    tests++;
    if (last_err !== err || last_rdata !== rdata) begin
      fails++;
      $display("FAIL %s got err=%b rdata=%h exp err=%b rdata=%h", name, last_err, last_rdata, err, rdata);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    rst = 1'b0;
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state got ready=%b valid=%b rdata=%h err=%b exp 1 0 0 0", req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    tick();
  endtask

  task automatic test_write_read();
    int r;
    r = rsp_cnt;
    do_req(1'b1, BASE + 32'd4, 32'hDEAD_BEEF, 4'hF);
    drain();
    check_last("write_rsp", 1'b0, 32'h0);
    do_req(1'b0, BASE + 32'd4, 32'h0, 4'hF);
    drain();
    check_last("read_back", 1'b0, 32'hDEAD_BEEF);
    tests++;
    if (rsp_cnt - r !== 2) begin
      fails++;
      $display("FAIL write_read_count got=%0d exp=2", rsp_cnt - r);
    end
  endtask

  task automatic test_errors();
    do_req(1'b1, BASE, 32'h0BAD_F00D, 4'hF);
    drain();
    do_req(1'b0, BASE + 32'd2, 32'h0, 4'hF);
    drain();
    check_last("misaligned_read", 1'b1, 32'h0);
    do_req(1'b1, BASE + 32'(4 * DEPTH), 32'h5555_5555, 4'hF);
    drain();
    check_last("out_of_range_write", 1'b1, 32'h0);
    do_req(1'b1, 32'h0, 32'h6666_6666, 4'hF);
    drain();
    check_last("below_base_write", 1'b1, 32'h0);
    do_req(1'b1, BASE + 32'd1, 32'h7777_7777, 4'hF);
    drain();
    check_last("misaligned_write", 1'b1, 32'h0);
    do_req(1'b0, BASE, 32'h0, 4'hF);
    drain();
    check_last("word0_intact", 1'b0, 32'h0BAD_F00D);
  endtask

  task automatic test_back_to_back();
    int s, r, n;
    s = acc_cnt;
    r = rsp_cnt;
    req_valid = 1'b1;
    req_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_addr = (i % 2 == 0) ? BASE + 32'd4 : BASE;
      tick();
    end
    req_valid = 1'b0;
    drain();
    n = acc_cnt - s;
    tests++;
    if (n !== (10 + LAT) / (LAT + 1)) begin
      fails++;
      $display("FAIL b2b_accepts got=%0d exp=%0d", n, (10 + LAT) / (LAT + 1));
    end
    for (int k = acc_cyc.size() - n + 1; k < acc_cyc.size(); k++) begin
      tests++;
      if (acc_cyc[k] - acc_cyc[k-1] !== LAT + 1) begin
        fails++;
        $display("FAIL b2b_spacing got=%0d exp=%0d", acc_cyc[k] - acc_cyc[k-1], LAT + 1);
      end
    end
    tests++;
    if (rsp_cnt - r !== n) begin
      fails++;
      $display("FAIL b2b_responses got=%0d exp=%0d", rsp_cnt - r, n);
    end
  endtask

  task automatic test_reset_mid();
    int r;
    do_req(1'b1, BASE + 32'h10, 32'h1234_5678, 4'hF);
    drain();
    r = rsp_cnt;
    do_req(1'b0, BASE + 32'h10, 32'h0, 4'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    tests++;
    if (rsp_cnt !== r || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid got rsps=%0d ready=%b exp rsps=%0d ready=1", rsp_cnt - r, req_ready, 0);
    end
    rst = 1'b1;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = BASE + 32'h10;
    req_wdata = 32'hCAFE_F00D;
    tick();
    rst = 1'b0;
    req_valid = 1'b0;
    tick();
    do_req(1'b0, BASE + 32'h10, 32'h0, 4'hF);
    drain();
    check_last("write_survives_reset", 1'b0, 32'h1234_5678);
  endtask

`ifdef DMEM_BYTE_EN_EN
  task automatic test_byte_en();
    int r;
    do_req(1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF);
    drain();
    do_req(1'b1, BASE + 32'h20, 32'h0000_00AA, 4'b0001);
    drain();
    do_req(1'b0, BASE + 32'h20, 32'h0, 4'h0);
    drain();
    check_last("byte_en_merge", 1'b0, 32'hFFFF_FFAA);
    r = rsp_cnt;
    do_req(1'b1, BASE + 32'h20, 32'h0, 4'h0);
    drain();
    tests++;
    if (rsp_cnt - r !== 1) begin
      fails++;
      $display("FAIL be0_response got=%0d exp=1", rsp_cnt - r);
    end
    do_req(1'b0, BASE + 32'h20, 32'h0, 4'hF);
    drain();
    check_last("be0_noop", 1'b0, 32'hFFFF_FFAA);
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_back_to_back();
    test_reset_mid();
`ifdef DMEM_BYTE_EN_EN
    test_byte_en();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
